// File: rtl/btle_tx_framer.sv
// btle_tx_framer: frames one BLE LE packet (preamble, access address, PDU,
// CRC24) and emits it LSB first as a bit stream with valid/last strobes, at
// LE 1M or LE 2M rate. Header, payload and CRC are whitened.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   tx_start, tx_abort    start pulse (IDLE only) / abort (any busy state)
//   phy_2m, len_8bit      PHY rate select / full-octet length select
//   access_address        32-bit access address
//   crc_init              CRC LFSR initial value
//   channel_number        whitening seed and advertising-channel detect
//   pdu_wr_en/addr/data   PDU memory write port (ignored while busy)
//   phy_bit, phy_bit_valid, phy_bit_last   output bit stream
//   tx_busy, tx_done, tx_aborted           handshake
module btle_tx_framer #(
    parameter int unsigned CLK_PER_BIT    = 16,
    parameter int unsigned PDU_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_start,
    input  logic                      tx_abort,
    input  logic                      phy_2m,
    input  logic                      len_8bit,
    input  logic [31:0]               access_address,
    input  logic [23:0]               crc_init,
    input  logic [5:0]                channel_number,
    input  logic                      pdu_wr_en,
    input  logic [PDU_ADDR_WIDTH-1:0] pdu_wr_addr,
    input  logic [7:0]                pdu_wr_data,
    output logic                      phy_bit,
    output logic                      phy_bit_valid,
    output logic                      phy_bit_last,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      tx_aborted
);

    localparam int unsigned AW          = PDU_ADDR_WIDTH;
    localparam int unsigned DEPTH       = 2 ** AW;
    localparam int unsigned TW          = $clog2(CLK_PER_BIT);
    localparam int unsigned CW          = 11;
    localparam int unsigned LEN_MAX_RAW = DEPTH - 2;
    localparam int unsigned LEN_CAP     = (LEN_MAX_RAW > 510) ? 510 : LEN_MAX_RAW;
    localparam logic [8:0]  LEN_CAP9    = 9'(LEN_CAP);
    localparam logic [TW-1:0] RELOAD_1M = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] RELOAD_2M = TW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ACCESS,
        S_HEADER,
        S_PAYLOAD,
        S_CRC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // latched packet configuration
    logic          phy2m_q;
    logic          len8_q;
    logic [31:0]   aa_q;
    logic [5:0]    chan_q;

    // datapath
    logic [TW-1:0] timer_q;
    logic [CW-1:0] bit_cnt_q;
    logic [7:0]    sr_q;
    logic [7:0]    len_q;
    logic [23:0]   crc_q;
    logic [6:0]    wht_q;
    logic [AW-1:0] rd_ptr_q;
    logic [7:0]    rdata_q;
    logic [7:0]    mem_q [DEPTH];

    // registered outputs
    logic phy_bit_q, phy_bit_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic aborted_q, aborted_d;

    logic          start_c;
    logic          abort_c;
    logic          active_c;
    logic          emit_c;
    logic          field_end_c;
    logic          whiten_c;
    logic          raw_bit_c;
    logic          tx_bit_c;
    logic          crc_fb_c;
    logic [23:0]   crc_next_c;
    logic [6:0]    wht_next_c;
    logic          adv_c;
    logic [7:0]    len_raw_c;
    logic [7:0]    len_clamp_c;

    assign start_c  = (state_q == S_IDLE) && tx_start;
    assign abort_c  = (state_q != S_IDLE) && tx_abort;
    assign active_c = (state_q == S_PREAMBLE) || (state_q == S_ACCESS) ||
                      (state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                      (state_q == S_CRC);
    // abort wins over any bit that would be emitted in the same cycle
    assign emit_c   = active_c && (timer_q == '0) && !abort_c;
    assign whiten_c = (state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                      (state_q == S_CRC);

    // last bit of the current field
    always_comb begin
        field_end_c = 1'b0;
        case (state_q)
            S_PREAMBLE: field_end_c = (bit_cnt_q == (phy2m_q ? 11'd15 : 11'd7));
            S_ACCESS:   field_end_c = (bit_cnt_q == 11'd31);
            S_HEADER:   field_end_c = (bit_cnt_q == 11'd15);
            S_PAYLOAD:  field_end_c = (bit_cnt_q == {len_q - 8'd1, 3'b111});
            S_CRC:      field_end_c = (bit_cnt_q == 11'd23);
            default:    field_end_c = 1'b0;
        endcase
    end

    // unwhitened bit for the current position
    always_comb begin
        raw_bit_c = 1'b0;
        case (state_q)
            S_PREAMBLE: raw_bit_c = bit_cnt_q[0] ^ aa_q[0];
            S_ACCESS:   raw_bit_c = aa_q[bit_cnt_q[4:0]];
            S_HEADER:   raw_bit_c = sr_q[0];
            S_PAYLOAD:  raw_bit_c = sr_q[0];
            S_CRC:      raw_bit_c = crc_q[23];
            default:    raw_bit_c = 1'b0;
        endcase
    end

    assign tx_bit_c   = raw_bit_c ^ (whiten_c & wht_q[6]);
    assign crc_fb_c   = crc_q[23] ^ raw_bit_c;
    assign crc_next_c = {crc_q[22:0], crc_fb_c} ^ ({24{crc_fb_c}} & 24'h00065A);
    assign wht_next_c = {wht_q[5], wht_q[4], wht_q[3] ^ wht_q[6], wht_q[2],
                         wht_q[1], wht_q[0], wht_q[6]};

    // length decode of octet 1 (advertising channels keep 6 bits in legacy mode)
    assign adv_c       = (chan_q >= 6'd37) && (chan_q <= 6'd39);
    assign len_raw_c   = len8_q ? rdata_q :
                         (adv_c ? {2'b00, rdata_q[5:0]} : {3'b000, rdata_q[4:0]});
    assign len_clamp_c = ({1'b0, len_raw_c} > LEN_CAP9) ? 8'(LEN_CAP) : len_raw_c;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (abort_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (tx_start) state_d = S_PREAMBLE;
                S_PREAMBLE: if (emit_c && field_end_c) state_d = S_ACCESS;
                S_ACCESS:   if (emit_c && field_end_c) state_d = S_HEADER;
                S_HEADER:   if (emit_c && field_end_c) state_d = (len_q == 8'd0) ? S_CRC : S_PAYLOAD;
                S_PAYLOAD:  if (emit_c && field_end_c) state_d = S_CRC;
                S_CRC:      if (emit_c && field_end_c) state_d = S_DONE;
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // output logic (next values of the registered outputs)
    always_comb begin
        phy_bit_d = phy_bit_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        busy_d    = (state_d != S_IDLE);
        if (abort_c) begin
            aborted_d = 1'b1;
        end else begin
            if (emit_c) begin
                phy_bit_d = tx_bit_c;
                valid_d   = 1'b1;
                last_d    = (state_q == S_CRC) && field_end_c;
            end
            if (state_q == S_DONE) done_d = 1'b1;
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phy_bit_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            phy_bit_q <= phy_bit_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // config latch, bit timer, shift/CRC/whitening registers, read pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phy2m_q   <= 1'b0;
            len8_q    <= 1'b0;
            aa_q      <= '0;
            chan_q    <= '0;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            len_q     <= '0;
            crc_q     <= '0;
            wht_q     <= '0;
            rd_ptr_q  <= '0;
        end else if (start_c) begin
            phy2m_q   <= phy_2m;
            len8_q    <= len_8bit;
            aa_q      <= access_address;
            chan_q    <= channel_number;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            crc_q     <= crc_init;
            wht_q     <= {channel_number[0], channel_number[1], channel_number[2],
                          channel_number[3], channel_number[4], channel_number[5], 1'b1};
            rd_ptr_q  <= '0;
        end else if (emit_c) begin
            timer_q   <= phy2m_q ? RELOAD_2M : RELOAD_1M;
            bit_cnt_q <= field_end_c ? '0 : bit_cnt_q + CW'(1);
            if (whiten_c) wht_q <= wht_next_c;
            case (state_q)
                S_ACCESS: begin
                    // header octet has been waiting in rdata_q since the start
                    if (field_end_c) begin
                        sr_q     <= rdata_q;
                        rd_ptr_q <= AW'(1);
                    end
                end
                S_HEADER, S_PAYLOAD: begin
                    crc_q <= crc_next_c;
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        // octet boundary: take the prefetched octet, fetch the next
                        sr_q     <= rdata_q;
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        if ((state_q == S_HEADER) && !bit_cnt_q[3]) len_q <= len_clamp_c;
                    end else begin
                        sr_q <= {1'b0, sr_q[7:1]};
                    end
                end
                S_CRC: crc_q <= {crc_q[22:0], 1'b0};
                default: ;
            endcase
        end else if (active_c) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    // PDU memory: synchronous read of the prefetch pointer, writes only when idle
    always_ff @(posedge clk) begin
        if (pdu_wr_en && !busy_q) mem_q[pdu_wr_addr] <= pdu_wr_data;
        rdata_q <= mem_q[rd_ptr_q];
    end

    assign phy_bit       = phy_bit_q;
    assign phy_bit_valid = valid_q;
    assign phy_bit_last  = last_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign tx_aborted    = aborted_q;

endmodule

// File: tb/tb_btle_tx_framer.sv
// Directed bench for btle_tx_framer: table of packet vectors with hand-computed
// length, bit count, strobe period and done cycle; a software model supplies
// the expected whitened bit stream.
module tb_btle_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic        tx_abort;
    logic        phy_2m;
    logic        len_8bit;
    logic [31:0] access_address;
    logic [23:0] crc_init;
    logic [5:0]  channel_number;
    logic        pdu_wr_en;
    logic [8:0]  pdu_wr_addr;
    logic [7:0]  pdu_wr_data;
    logic        phy_bit;
    logic        phy_bit_valid;
    logic        phy_bit_last;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_aborted;

    btle_tx_framer #(.CLK_PER_BIT(16), .PDU_ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_abort(tx_abort),
        .phy_2m(phy_2m), .len_8bit(len_8bit), .access_address(access_address),
        .crc_init(crc_init), .channel_number(channel_number),
        .pdu_wr_en(pdu_wr_en), .pdu_wr_addr(pdu_wr_addr), .pdu_wr_data(pdu_wr_data),
        .phy_bit(phy_bit), .phy_bit_valid(phy_bit_valid), .phy_bit_last(phy_bit_last),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_aborted(tx_aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          phy2m;
        bit          len8;
        logic [5:0]  ch;
        logic [31:0] aa;
        logic [23:0] ci;
        logic [7:0]  hdr;
        logic [7:0]  len_oct;
        logic [7:0]  seed;
        int          exp_len;
        int          exp_n;
        int          exp_p;
        int          exp_done;
    } vec_t;

    vec_t       tv [6];
    logic [7:0] pdu [512];
    logic       exp_bits [2200];
    int         exp_cnt;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        phy_2m         = v.phy2m;
        len_8bit       = v.len8;
        access_address = v.aa;
        crc_init       = v.ci;
        channel_number = v.ch;
    endtask

    task automatic write_pdu(input vec_t v);
        pdu[0] = v.hdr;
        pdu[1] = v.len_oct;
        for (int i = 2; i < v.exp_len + 2; i++) pdu[i] = 8'(i * 29 + int'(v.seed));
        for (int i = 0; i < v.exp_len + 2; i++) begin
            @(negedge clk);
            pdu_wr_en   = 1'b1;
            pdu_wr_addr = 9'(i);
            pdu_wr_data = pdu[i];
        end
        @(negedge clk);
        pdu_wr_en = 1'b0;
    endtask

    // reference bit stream built straight from the packet format
    task automatic gen_model(input vec_t v);
        logic [23:0] c;
        logic [6:0]  w;
        logic        d;
        logic        fb;
        int          n;
        n = 0;
        c = v.ci;
        w = {v.ch[0], v.ch[1], v.ch[2], v.ch[3], v.ch[4], v.ch[5], 1'b1};
        for (int i = 0; i < (v.phy2m ? 16 : 8); i++) begin
            exp_bits[n] = i[0] ^ v.aa[0];
            n++;
        end
        for (int i = 0; i < 32; i++) begin
            exp_bits[n] = v.aa[i];
            n++;
        end
        for (int o = 0; o < v.exp_len + 2; o++) begin
            for (int b = 0; b < 8; b++) begin
                d  = pdu[o][b];
                fb = c[23] ^ d;
                c  = c << 1;
                c[0]  = fb;
                c[1]  = c[1] ^ fb;
                c[3]  = c[3] ^ fb;
                c[4]  = c[4] ^ fb;
                c[6]  = c[6] ^ fb;
                c[9]  = c[9] ^ fb;
                c[10] = c[10] ^ fb;
                exp_bits[n] = d ^ w[6];
                n++;
                w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
            end
        end
        for (int i = 23; i >= 0; i--) begin
            exp_bits[n] = c[i] ^ w[6];
            n++;
            w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        end
        exp_cnt = n;
    endtask

    // abort_at / rst_at: strobe count at which to abort or reset (-1 = never)
    task automatic run_pkt(input vec_t v, input bit load, input int abort_at, input int rst_at,
                           input bit disturb, input bit pre_started, input bit chain);
        int c, ns, bit_err, first_err, sp_err, last_cnt, last_idx;
        int done_c, done_busy, ab_cnt, ab_c, busy1, stop_c;
        bit ab_drv, rst_hit;
        ns = 0; bit_err = 0; first_err = -1; sp_err = 0; last_cnt = 0; last_idx = -1;
        done_c = -1; done_busy = -1; ab_cnt = 0; ab_c = -1; busy1 = -1;
        ab_drv = 1'b0; rst_hit = 1'b0;
        if (load) write_pdu(v);
        gen_model(v);
        if (!pre_started) begin
            @(negedge clk);
            drive_cfg(v);
            tx_start = 1'b1;
        end
        @(posedge clk);
        #1 tx_start = 1'b0;
        c = 1;
        stop_c = 3 + (v.exp_n - 1) * v.exp_p + 10;
        while (c <= stop_c) begin
            @(negedge clk);
            if (c == 1) busy1 = int'(tx_busy);
            if (phy_bit_valid) begin
                if (ns < exp_cnt && phy_bit !== exp_bits[ns]) begin
                    if (bit_err == 0) first_err = ns;
                    bit_err++;
                end
                if (c != 2 + ns * v.exp_p) sp_err++;
                if (phy_bit_last) begin
                    last_cnt++;
                    last_idx = ns;
                end
                ns++;
            end
            if (tx_aborted) begin
                ab_cnt++;
                ab_c   = c;
                stop_c = c + 3 * v.exp_p;
            end
            if (tx_done) begin
                done_c    = c;
                done_busy = int'(tx_busy);
                if (chain) tx_start = 1'b1;
                break;
            end
            if (abort_at >= 0 && ns == abort_at && !ab_drv) begin
                tx_abort = 1'b1;
                ab_drv   = 1'b1;
            end
            if (rst_at >= 0 && ns == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_outputs", 32'({phy_bit, phy_bit_valid, phy_bit_last, tx_busy, tx_done, tx_aborted}), 0);
                rst_hit = 1'b1;
                break;
            end
            if (disturb && c == 60) begin
                pdu_wr_en      = 1'b1;
                pdu_wr_addr    = 9'd2;
                pdu_wr_data    = ~pdu[2];
                tx_start       = 1'b1;
                phy_2m         = ~v.phy2m;
                len_8bit       = ~v.len8;
                access_address = ~v.aa;
                crc_init       = ~v.ci;
                channel_number = v.ch ^ 6'd37;
            end
            @(posedge clk);
            #1;
            tx_abort  = 1'b0;
            pdu_wr_en = 1'b0;
            tx_start  = 1'b0;
            c++;
        end
        chk("busy_cycle1", busy1, 1);
        chk("bit_errors", bit_err, 0);
        if (bit_err != 0) $display("  first bad strobe index %0d", first_err);
        chk("strobe_spacing_errors", sp_err, 0);
        if (rst_at >= 0) begin
            chk("rst_reached", 32'(rst_hit), 1);
        end else if (abort_at >= 0) begin
            chk("abort_strobes", ns, abort_at);
            chk("abort_pulses", ab_cnt, 1);
            chk("abort_cycle", ab_c, 3 + (abort_at - 1) * v.exp_p);
            chk("abort_last", last_cnt, 0);
            chk("abort_done", done_c, -1);
            chk("abort_busy_after", 32'(tx_busy), 0);
        end else begin
            chk("strobes", ns, v.exp_n);
            chk("last_count", last_cnt, 1);
            chk("last_index", last_idx, v.exp_n - 1);
            chk("done_cycle", done_c, v.exp_done);
            chk("busy_at_done", done_busy, 0);
        end
    endtask

    initial begin
        // phy2m len8 ch     aa            ci           hdr    len_oct seed   len  N     P   done
        tv[0] = '{1'b0, 1'b0, 6'd37, 32'h8E89BED6, 24'h555555, 8'h40, 8'h00, 8'h00, 0,   80,   16, 1267};
        tv[1] = '{1'b1, 1'b1, 6'd5,  32'h71764129, 24'h123456, 8'h02, 8'hFF, 8'h11, 255, 2128, 8,  17019};
        tv[2] = '{1'b0, 1'b0, 6'd10, 32'h8E89BED6, 24'hABCDEF, 8'h01, 8'hFF, 8'h5A, 31,  328,  16, 5235};
        tv[3] = '{1'b1, 1'b0, 6'd38, 32'h8E89BED6, 24'h555555, 8'h42, 8'hFF, 8'hC3, 63,  592,  8,  4731};
        tv[4] = '{1'b0, 1'b0, 6'd0,  32'h12345679, 24'h000001, 8'h03, 8'hE3, 8'h77, 3,   104,  16, 1651};
        tv[5] = '{1'b1, 1'b1, 6'd39, 32'hD6BE898F, 24'hFFFFFF, 8'h46, 8'h00, 8'h00, 0,   88,   8,  699};

        rst = 1'b1; tx_start = 1'b0; tx_abort = 1'b0; pdu_wr_en = 1'b0;
        pdu_wr_addr = '0; pdu_wr_data = '0;
        drive_cfg(tv[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({phy_bit, phy_bit_valid, phy_bit_last, tx_busy, tx_done, tx_aborted}), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_pkt(tv[i], 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);

        // abort mid-payload, then a clean packet from the same memory
        run_pkt(tv[2], 1'b1, 150, -1, 1'b0, 1'b0, 1'b0);
        run_pkt(tv[2], 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        // writes, starts and config changes while busy are ignored
        run_pkt(tv[4], 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
        run_pkt(tv[4], 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        // reset during CRC, then a bit-exact packet
        run_pkt(tv[4], 1'b1, -1, 90, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_outputs", 32'({phy_bit, phy_bit_valid, phy_bit_last, tx_busy, tx_done, tx_aborted}), 0);
        rst = 1'b0;
        run_pkt(tv[4], 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);

        // start accepted in the same cycle as tx_done
        run_pkt(tv[5], 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
        run_pkt(tv[5], 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
